// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, in-order memory requests, response buffer and
// decode handshake, with redirect that flushes and discards wrong-path responses.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_reg, pc_next;
  logic [31:0]   rsp_pc_reg, rsp_pc_next;
  logic [CW-1:0] inflight_reg, inflight_next;
  logic [CW-1:0] discard_reg, discard_next;
  logic [CW-1:0] count_reg, count_next;
  logic [AW-1:0] head_reg, head_next;
  logic [AW-1:0] tail_reg, tail_next;
  logic          started_reg;

  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem    [FIFO_DEPTH];

  logic [CW:0]   credit_used;
  logic [31:0]   redirect_aligned;
  logic          fifo_empty, req_fire, rsp_eff, push, pop;

  always_comb begin
    credit_used      = {1'b0, inflight_reg} + {1'b0, count_reg};
    redirect_aligned = redirect_pc & ~32'h0000_0003;
    fifo_empty       = (count_reg == '0);

    // started_reg keeps requests quiet during the first cycle out of reset
    imem_req_valid = rst_n & started_reg & ~redirect_valid &
                     (credit_used < (CW+1)'(FIFO_DEPTH));
    imem_req_addr  = rst_n ? pc_reg : RESET_PC;
    id_valid       = rst_n & ~fifo_empty & ~redirect_valid;
    id_instr       = fifo_empty ? 32'h0 : instr_mem[head_reg];
    id_pc          = fifo_empty ? 32'h0 : pc_mem[head_reg];
    id_pc_plus4    = fifo_empty ? 32'h0 : pc_mem[head_reg] + 32'd4;

    req_fire = imem_req_valid & imem_req_ready;
    rsp_eff  = imem_rsp_valid & (inflight_reg != '0);
    pop      = id_valid & id_ready;
    push     = rsp_eff & (discard_reg == '0) & ~redirect_valid;

    pc_next       = pc_reg;
    rsp_pc_next   = rsp_pc_reg;
    inflight_next = inflight_reg;
    discard_next  = discard_reg;
    count_next    = count_reg;
    head_next     = head_reg;
    tail_next     = tail_reg;

    if (redirect_valid) begin
      // every response still owed belongs to the old path
      pc_next       = redirect_aligned;
      rsp_pc_next   = redirect_aligned;
      inflight_next = inflight_reg - CW'(rsp_eff);
      discard_next  = inflight_reg - CW'(rsp_eff);
      count_next    = '0;
      head_next     = '0;
      tail_next     = '0;
    end else begin
      if (req_fire)
        pc_next = pc_reg + 32'd4;
      inflight_next = inflight_reg + CW'(req_fire) - CW'(rsp_eff);
      if (rsp_eff && discard_reg != '0)
        discard_next = discard_reg - CW'(1);
      // surviving responses return in request order, so their tag just counts up
      if (push)
        rsp_pc_next = rsp_pc_reg + 32'd4;
      count_next = count_reg + CW'(push) - CW'(pop);
      head_next  = head_reg + AW'(pop);
      tail_next  = tail_reg + AW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg       <= RESET_PC;
      rsp_pc_reg   <= RESET_PC;
      inflight_reg <= '0;
      discard_reg  <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
      started_reg  <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      rsp_pc_reg   <= rsp_pc_next;
      inflight_reg <= inflight_next;
      discard_reg  <= discard_next;
      count_reg    <= count_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      started_reg  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_reg] <= imem_rsp_data;
      pc_mem[tail_reg]    <= rsp_pc_reg;
    end
  end
endmodule
